// File: rtl/seg_scan_driver_if.sv
// Digit-scan bus between the upstream counter/load source and the seven-segment driver.
interface seg_scan_driver_if;
  logic [1:0]  count;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pend;
  logic        commit;

  modport master (
    output count, value, dp_in, load,
    input  an, seg, dp, pend, commit
  );

  modport slave (
    input  count, value, dp_in, load,
    output an, seg, dp, pend, commit
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with anti-ghost blanking and frame-synchronous word commit.
// Optional leading-zero suppression under macro SEG_LEADING_ZERO_BLANK_EN; all outputs registered (1 cycle).
module seg_scan_driver #(
  parameter int BLANK_CYCLES = 16
) (
  input logic            clk,
  input logic            reset,
  seg_scan_driver_if.slave bus
);

  localparam logic [7:0] BLANK_LD = 8'(BLANK_CYCLES);

  logic [1:0]  r_cnt_q;
  logic [7:0]  r_blank;
  logic [15:0] r_pend_val;
  logic [3:0]  r_pend_dp;
  logic        r_pend;
  logic [15:0] r_sh_val;
  logic [3:0]  r_sh_dp;
  logic        r_commit;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_chg;
  logic        w_take;
  logic [7:0]  w_blank_nx;
  logic [15:0] w_sh_val_nx;
  logic [3:0]  w_sh_dp_nx;
  logic [3:0]  w_nib;
  logic [6:0]  w_seg_dec;
  logic [6:0]  w_seg_out;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Outputs are computed from next-state values so every input shows up exactly one cycle later.
  always_comb begin
    w_chg       = (bus.count != r_cnt_q);
    w_take      = (r_cnt_q == 2'd3) && (bus.count == 2'd0) && (bus.load || r_pend);
    w_blank_nx  = w_chg ? BLANK_LD : ((r_blank != 8'd0) ? (r_blank - 8'd1) : 8'd0);
    w_sh_val_nx = r_sh_val;
    w_sh_dp_nx  = r_sh_dp;
    if (w_take) begin
      w_sh_val_nx = bus.load ? bus.value : r_pend_val;
      w_sh_dp_nx  = bus.load ? bus.dp_in : r_pend_dp;
    end
    case (bus.count)
      2'd0:    w_nib = w_sh_val_nx[3:0];
      2'd1:    w_nib = w_sh_val_nx[7:4];
      2'd2:    w_nib = w_sh_val_nx[11:8];
      default: w_nib = w_sh_val_nx[15:12];
    endcase
    w_seg_dec = hex7(w_nib);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Digit k is dark when nibbles k..3 are all zero; digit 0 always shows.
    if ((bus.count != 2'd0) && ((w_sh_val_nx >> {bus.count, 2'b00}) == 16'd0))
      w_seg_out = 7'b1111111;
    else
      w_seg_out = w_seg_dec;
`else
    w_seg_out = w_seg_dec;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_q    <= 2'd0;
      r_blank    <= BLANK_LD;
      r_pend_val <= 16'd0;
      r_pend_dp  <= 4'd0;
      r_pend     <= 1'b0;
      r_sh_val   <= 16'd0;
      r_sh_dp    <= 4'd0;
      r_commit   <= 1'b0;
      r_an       <= 4'b1111;
      r_seg      <= 7'b1111111;
      r_dp       <= 1'b1;
    end else begin
      r_cnt_q  <= bus.count;
      r_blank  <= w_blank_nx;
      r_sh_val <= w_sh_val_nx;
      r_sh_dp  <= w_sh_dp_nx;
      if (w_take) begin
        r_pend   <= 1'b0;
        r_commit <= 1'b1;
      end else begin
        r_commit <= 1'b0;
        if (bus.load) begin
          r_pend_val <= bus.value;
          r_pend_dp  <= bus.dp_in;
          r_pend     <= 1'b1;
        end
      end
      if (w_blank_nx != 8'd0) begin
        r_an  <= 4'b1111;
        r_seg <= 7'b1111111;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << bus.count);
        r_seg <= w_seg_out;
        r_dp  <= ~w_sh_dp_nx[bus.count];
      end
    end
  end

  assign bus.an     = r_an;
  assign bus.seg    = r_seg;
  assign bus.dp     = r_dp;
  assign bus.pend   = r_pend;
  assign bus.commit = r_commit;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed and randomized checks of seg_scan_driver against a cycle-indexed reference model (BLANK_CYCLES 16 and 0).
module tb_seg_scan_driver;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  seg_scan_driver_if if_a ();
  seg_scan_driver_if if_b ();

  seg_scan_driver #(.BLANK_CYCLES(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  seg_scan_driver #(.BLANK_CYCLES(0))  dut_b (.clk(clk), .reset(reset), .bus(if_b));

  always #5 clk = ~clk;

  localparam logic [6:0] HEX7 [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: blanking measured as edges elapsed since the last reset or digit change.
  int          m_cyc;
  int          m_last_evt;
  logic        m_rst;
  logic [1:0]  m_cnt;
  logic        m_pend;
  logic [15:0] m_pend_val;
  logic [3:0]  m_pend_dp;
  logic [15:0] m_sh_val;
  logic [3:0]  m_sh_dp;
  logic        m_commit;
  logic [1:0]  cur_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_disp(input int blank);
    logic [3:0] nib;
    logic [6:0] s;
    if (m_rst || ((m_cyc - m_last_evt) < blank))
      return {4'b1111, 7'b1111111, 1'b1};
    nib = 4'((m_sh_val >> (4 * int'(m_cnt))) & 16'hF);
    s   = HEX7[nib];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (m_cnt != 2'd0 && (m_sh_val >> (4 * int'(m_cnt))) == 16'd0) s = 7'b1111111;
`endif
    return {~(4'b0001 << m_cnt), s, ~m_sh_dp[m_cnt]};
  endfunction

  task automatic tick(input logic rst, input logic [1:0] c, input logic ld,
                      input logic [15:0] v, input logic [3:0] d);
    logic [11:0] ea, eb;
    reset = rst;
    if_a.count = c; if_a.load = ld; if_a.value = v; if_a.dp_in = d;
    if_b.count = c; if_b.load = ld; if_b.value = v; if_b.dp_in = d;
    cur_c = c;
    @(posedge clk);
    m_cyc++;
    m_rst = rst;
    if (rst) begin
      m_cnt = 2'd0; m_last_evt = m_cyc; m_pend = 1'b0;
      m_pend_val = 16'd0; m_pend_dp = 4'd0;
      m_sh_val = 16'd0; m_sh_dp = 4'd0; m_commit = 1'b0;
    end else begin
      m_commit = 1'b0;
      if (m_cnt == 2'd3 && c == 2'd0 && (ld || m_pend)) begin
        m_sh_val = ld ? v : m_pend_val;
        m_sh_dp  = ld ? d : m_pend_dp;
        m_pend   = 1'b0;
        m_commit = 1'b1;
      end else if (ld) begin
        m_pend_val = v; m_pend_dp = d; m_pend = 1'b1;
      end
      if (c != m_cnt) m_last_evt = m_cyc;
      m_cnt = c;
    end
    #1;
    ea = exp_disp(16);
    eb = exp_disp(0);
    chk("a_an",     if_a.an,     ea[11:8]);
    chk("a_seg",    if_a.seg,    ea[7:1]);
    chk("a_dp",     if_a.dp,     ea[0]);
    chk("a_pend",   if_a.pend,   m_pend);
    chk("a_commit", if_a.commit, m_commit);
    chk("b_an",     if_b.an,     eb[11:8]);
    chk("b_seg",    if_b.seg,    eb[7:1]);
    chk("b_dp",     if_b.dp,     eb[0]);
    chk("b_pend",   if_b.pend,   m_pend);
    chk("b_commit", if_b.commit, m_commit);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, cur_c, 1'b0, 16'd0, 4'd0);
  endtask

  initial begin
    logic [6:0] lz_seg;
    int r;
    logic [1:0] c;
    clk = 1'b0; reset = 1'b1; n_cmp = 0; n_bad = 0;
    m_cyc = 0; m_last_evt = 0; m_rst = 1'b1; m_cnt = 2'd0; m_pend = 1'b0;
    m_pend_val = 16'd0; m_pend_dp = 4'd0; m_sh_val = 16'd0; m_sh_dp = 4'd0;
    m_commit = 1'b0; cur_c = 2'd0;

    // Reset for two cycles, then 16 blank cycles before digit 0 appears.
    tick(1'b1, 2'd0, 1'b1, 16'hFFFF, 4'hF);
    tick(1'b1, 2'd0, 1'b0, 16'd0, 4'd0);
    chk("rst_an",   if_a.an,   4'b1111);
    chk("rst_seg",  if_a.seg,  7'b1111111);
    chk("rst_pend", if_a.pend, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
      if (k == 15) chk("pow_blank_an", if_a.an, 4'b1111);
      if (k == 16) begin
        chk("pow_show_an",  if_a.an,  4'b1110);
        chk("pow_show_seg", if_a.seg, 7'b1000000);
      end
    end

    // Load 12AF at count 1, commit at the 3->0 edge, then scan digits.
    tick(1'b0, 2'd1, 1'b1, 16'h12AF, 4'b0000);
    chk("w1_pend1", if_b.pend, 1'b1);
    tick(1'b0, 2'd2, 1'b0, 16'd0, 4'd0);
    tick(1'b0, 2'd3, 1'b0, 16'd0, 4'd0);
    chk("w1_pend3", if_b.pend, 1'b1);
    tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
    chk("w1_commit", if_b.commit, 1'b1);
    chk("w1_pend0",  if_b.pend,   1'b0);
    chk("w1_d0",     if_b.seg,    7'b0001110);
    tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
    chk("w1_commit_once", if_b.commit, 1'b0);
    tick(1'b0, 2'd1, 1'b0, 16'd0, 4'd0);
    chk("w1_d1", if_b.seg, 7'b0001000);
    tick(1'b0, 2'd2, 1'b0, 16'd0, 4'd0);
    chk("w1_d2", if_b.seg, 7'b0100100);
    tick(1'b0, 2'd3, 1'b0, 16'd0, 4'd0);
    chk("w1_d3", if_b.seg, 7'b1111001);

    // Two loads before a boundary: the later one wins.
    tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
    tick(1'b0, 2'd1, 1'b1, 16'h1111, 4'd0);
    tick(1'b0, 2'd2, 1'b1, 16'h2222, 4'd0);
    tick(1'b0, 2'd3, 1'b0, 16'd0, 4'd0);
    tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
    chk("ll_commit", if_b.commit, 1'b1);
    chk("ll_d0",     if_b.seg,    7'b0100100);
    tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
    chk("ll_commit_once", if_b.commit, 1'b0);

    // A 2->0 jump is not a frame boundary.
    tick(1'b0, 2'd2, 1'b1, 16'h5555, 4'd0);
    tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
    chk("jump_nocommit", if_b.commit, 1'b0);
    chk("jump_pend",     if_b.pend,   1'b1);

    // Zero blank: next digit on the very next cycle.
    tick(1'b0, 2'd1, 1'b0, 16'd0, 4'd0);
    chk("b0_an", if_b.an, 4'b1101);

    // Leading-zero word 0040.
    tick(1'b0, 2'd2, 1'b1, 16'h0040, 4'd0);
    tick(1'b0, 2'd3, 1'b0, 16'd0, 4'd0);
    tick(1'b0, 2'd0, 1'b0, 16'd0, 4'd0);
    chk("lz_d0", if_b.seg, 7'b1000000);
    tick(1'b0, 2'd1, 1'b0, 16'd0, 4'd0);
    chk("lz_d1", if_b.seg, 7'b0011001);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz_seg = 7'b1111111;
`else
    lz_seg = 7'b1000000;
`endif
    tick(1'b0, 2'd2, 1'b0, 16'd0, 4'd0);
    chk("lz_d2", if_b.seg, lz_seg);
    tick(1'b0, 2'd3, 1'b0, 16'd0, 4'd0);
    chk("lz_d3", if_b.seg, lz_seg);
    chk("lz_an3", if_b.an, 4'b0111);

    // Load coinciding with the 3->0 edge commits directly.
    tick(1'b0, 2'd0, 1'b1, 16'hBEEF, 4'b0101);
    chk("dir_commit", if_b.commit, 1'b1);
    chk("dir_pend",   if_b.pend,   1'b0);
    chk("dir_seg",    if_b.seg,    7'b0001110);
    chk("dir_dp",     if_b.dp,     1'b0);

    // Blank reload when the digit changes mid-blank.
    hold(20);
    chk("rl_settle_an", if_a.an, 4'b1110);
    tick(1'b0, 2'd1, 1'b0, 16'd0, 4'd0);
    hold(9);
    tick(1'b0, 2'd2, 1'b0, 16'd0, 4'd0);
    hold(15);
    chk("rl_still_blank", if_a.an, 4'b1111);
    hold(1);
    chk("rl_show_an",  if_a.an,  4'b1011);
    chk("rl_show_seg", if_a.seg, 7'b0000110);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 39));
      c = cur_c;
      if (r == 0) c = 2'($urandom_range(0, 3));
      else if (r < 3) c = cur_c + 2'd1;
      tick(($urandom_range(0, 199) == 0), c, ($urandom_range(0, 9) == 0),
           16'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter BLANK_CYCLES, default 16, giving the number of clk cycles all anodes stay off after each digit change (range 0..255).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on posedge clk.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port count, input, 2, the digit-select count from the upstream 2-bit counter, where 0 selects the rightmost digit.
REQ-005 The block SHALL have port value, input, 16, a hex display word, with nibble k shown on digit k.
REQ-006 The block SHALL have port dp_in, input, 4, decimal point enables, with bit k for digit k, active-high.
REQ-007 The block SHALL have port load, input, 1, a one-cycle strobe that captures value and dp_in.
REQ-008 The block SHALL have port an, output, 4, the digit anodes, active-low.
REQ-009 The block SHALL have port seg, output, 7, the segments {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have port dp, output, 1, the decimal point, active-low.
REQ-011 The block SHALL have port pend, output, 1, high while a loaded word awaits its frame commit.
REQ-012 The block SHALL have port commit, output, 1, a one-cycle pulse when the shadow word updates.

Function
REQ-013 Every output SHALL be registered, so a change on any input first appears at the outputs one cycle later.
REQ-014 The block SHALL register count into cnt_q every cycle; a digit change is the condition count != cnt_q.
REQ-015 On a digit change, the blank counter SHALL load BLANK_CYCLES and drive an=4'b1111 on the next cycle.
REQ-016 While the blank counter is nonzero, it SHALL decrement each cycle and an SHALL be 4'b1111.
REQ-017 When the blank counter is zero, an SHALL be active-low one-hot on bit cnt_q, and seg and dp SHALL reflect nibble cnt_q of the shadow word.
REQ-018 With BLANK_CYCLES=0, there SHALL be no blank interval, and the new digit SHALL appear one cycle after the count change.
REQ-019 A digit change occurring during blanking SHALL reload the blank counter.
REQ-020 The hex decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 A load SHALL write value and dp_in into the pending register and set pend.
REQ-022 A load while pend=1 SHALL overwrite the pending register, so the latest load wins.
REQ-023 A frame boundary is the cycle where cnt_q=3 and count=0; at a boundary with pend=1, the shadow SHALL take the pending data, pend SHALL clear, and commit SHALL pulse on the next cycle.
REQ-024 If load coincides with a frame boundary, the loaded value SHALL commit directly, with pend=0 afterwards and commit pulsed.
REQ-025 The shadow word SHALL never change except at a frame boundary, so no frame ever mixes old and new digits.
REQ-026 A count jump that is not 3->0 SHALL NOT commit.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL drive an=1111, seg=1111111, dp=1, pend=0, and commit=0.
REQ-028 Reset SHALL also clear the shadow and pending registers to 0, set cnt_q to 0, and load the blank counter with BLANK_CYCLES.
REQ-029 Reset SHALL take priority over load and over any commit in the same cycle, and a pending load in progress SHALL be discarded.
REQ-030 After reset release, the block SHALL show digit cnt_q once the blank interval expires.

Configuration
REQ-031 With macro SEG_LEADING_ZERO_BLANK_EN defined, digit k (k=3..1) SHALL output seg=1111111 when shadow nibbles k..3 are all zero; an and dp SHALL be unaffected, and digit 0 SHALL never be suppressed.
REQ-032 With SEG_LEADING_ZERO_BLANK_EN undefined, all four digits SHALL always be decoded, and no suppression logic SHALL be synthesized.

Verification
REQ-033 With reset held for 2 cycles, then released with count=0 and BLANK_CYCLES=16, the bench SHALL see an=1111 and seg=1111111 for 16 cycles, then an=1110 and seg=1000000.
REQ-034 With load value=16'h12AF at count=1, then count stepped 1->2->3->0, the bench SHALL see pend=1 until the 3->0 edge, then a single commit pulse, and digits 0..3 showing F, A, 2, 1.
REQ-035 With two loads, 16'h1111 then 16'h2222, before a frame boundary, the bench SHALL see only 16'h2222 committed and a single commit pulse.
REQ-036 With BLANK_CYCLES=0 and count changed 0->1, the bench SHALL see an=1101 on the next cycle with no all-off cycle.
REQ-037 With SEG_LEADING_ZERO_BLANK_EN defined and 16'h0040 committed, the bench SHALL see digits 3 and 2 with seg=1111111, digit 1 with 0011001, and digit 0 with 1000000; with the macro undefined, digits 3 and 2 SHALL show 1000000.
REQ-038 With load asserted in the same cycle as the 3->0 edge, the bench SHALL see commit high the next cycle, pend=0, and the new word displayed.
